// File: rtl/instr_mem_loader_if.sv
// Load byte stream plus instruction-fetch bus shared by the loader, the stream source and the processor.
interface instr_mem_loader_if;
  logic        LoadValid;
  logic [7:0]  LoadData;
  logic        LoadReady;
  logic [15:0] InstrAddr;
  logic [31:0] InstrMem;
  logic        CpuNReset;
  logic        Loaded;
  logic        LoadError;

  modport master (
    output LoadValid, LoadData, InstrAddr,
    input  LoadReady, InstrMem, CpuNReset, Loaded, LoadError
  );

  modport slave (
    input  LoadValid, LoadData, InstrAddr,
    output LoadReady, InstrMem, CpuNReset, Loaded, LoadError
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Fills the instruction store from a length-prefixed byte stream, then releases the processor and serves fetches.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (adds CHK/ERR states).
module instr_mem_loader #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input logic               Clock,
  input logic               Reset,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    RUN
`ifdef INSTR_LOADER_CHECKSUM_EN
    , CHK,
    ERR
`endif
  } state_e;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_e DONE_STATE = CHK;
`else
  localparam state_e DONE_STATE = RUN;
`endif

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic        loaded_q, loaded_d;
  logic        cpu_nreset_q, cpu_nreset_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic        load_error_q, load_error_d;
`endif

  logic             xfer;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem [DEPTH];

  assign xfer = bus.LoadValid && bus.LoadReady;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    mem_we     = 1'b0;
    mem_idx    = word_cnt_q[IDX_W-1:0];
    mem_wdata  = {bus.LoadData, word_buf_q};
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      LEN_HI: if (xfer) begin
        n_d[15:8] = bus.LoadData;
        state_d   = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        n_d[7:0] = bus.LoadData;
        state_d  = ({n_q[15:8], bus.LoadData} == 16'd0) ? DONE_STATE : DATA;
      end
      DATA: if (xfer) begin
        // Bytes arrive LSB first, so shifting in from the top leaves them in place after three bytes.
        byte_cnt_d = byte_cnt_q + 2'd1;
        word_buf_d = {bus.LoadData, word_buf_q[23:8]};
        if (byte_cnt_q == 2'd3) begin
          mem_we     = !Reset && ({16'd0, word_cnt_q} < DEPTH);
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == n_q - 16'd1) state_d = DONE_STATE;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK: if (xfer) state_d = (bus.LoadData == chk_q) ? RUN : ERR;
`endif
      default: ;
    endcase

`ifdef INSTR_LOADER_CHECKSUM_EN
    if (xfer && (state_q inside {LEN_HI, LEN_LO, DATA})) chk_d = chk_q ^ bus.LoadData;
    load_error_d = (state_d == ERR);
`endif
    loaded_d     = (state_d == RUN);
    cpu_nreset_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= LEN_HI;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      loaded_q     <= 1'b0;
      cpu_nreset_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk_q        <= '0;
      load_error_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      loaded_q     <= loaded_d;
      cpu_nreset_q <= cpu_nreset_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
      load_error_q <= load_error_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; stale words are masked by the fetch path instead.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_nop;

  assign fetch_idx = bus.InstrAddr[IDX_W+1:2];
  assign fetch_nop = !loaded_q
                  || ((bus.InstrAddr >> (IDX_W + 2)) != 16'd0)
                  || (32'(fetch_idx) >= 32'(n_q));

  assign bus.InstrMem  = fetch_nop ? 32'h0000_0000 : mem[fetch_idx];
  assign bus.LoadReady = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA)
`ifdef INSTR_LOADER_CHECKSUM_EN
                      || (state_q == CHK)
`endif
                      ;
  assign bus.Loaded    = loaded_q;
  assign bus.CpuNReset = cpu_nreset_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign bus.LoadError = load_error_q;
`else
  assign bus.LoadError = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and randomized loads against a word-list model.
module tb_instr_mem_loader;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [31:0] word_q_t [$];

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  // Reference model: the word list of the current load and whether it completed.
  word_q_t exp_words;
  int      exp_n = 0;
  bit      exp_loaded = 1'b0;

  function automatic logic [31:0] exp_fetch(input int addr);
    int idx;
    if (!exp_loaded) return 32'h0;
    if (addr >= 4 * DEPTH) return 32'h0;
    idx = addr / 4;
    if (idx >= exp_n || idx >= DEPTH) return 32'h0;
    return exp_words[idx];
  endfunction

  function automatic byte_q_t make_stream(input word_q_t w);
    byte_q_t    s;
    int         n;
    logic [7:0] x;
    n = w.size();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    foreach (w[k]) for (int j = 0; j < 4; j++) s.push_back(w[k][8*j +: 8]);
`ifdef INSTR_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    s.push_back(x);
`else
    x = 8'h00;
`endif
    return s;
  endfunction

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1;
    bus.LoadValid = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    exp_loaded = 1'b0;
    exp_n = 0;
    exp_words.delete();
  endtask

  // mode 0: valid every cycle; 1: alternate with a 20-cycle mid-word gap; 2: random stalls
  task automatic send_bytes(input byte_q_t b, input int mode, output bit early, output bit stuck);
    int i;
    int cyc;
    bit v;
    bit gap_done;
    i = 0; cyc = 0; gap_done = 1'b0;
    early = 1'b0; stuck = 1'b0;
    while (i < b.size()) begin
      @(negedge Clock);
      cyc++;
      if (cyc > 20000) begin
        stuck = 1'b1;
        break;
      end
      if (mode == 1 && i == 4 && !gap_done) begin
        gap_done = 1'b1;
        bus.LoadValid = 1'b0;
        repeat (20) begin
          @(negedge Clock);
          if (bus.CpuNReset !== 1'b0 || bus.Loaded !== 1'b0) early = 1'b1;
        end
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.LoadValid = v;
      bus.LoadData  = v ? b[i] : 8'($urandom);
      if (bus.CpuNReset !== 1'b0 || bus.Loaded !== 1'b0) early = 1'b1;
      if (v && bus.LoadReady === 1'b1) i++;
      @(posedge Clock);
    end
    @(negedge Clock);
    bus.LoadValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.LoadValid = 1'b0;
    bus.LoadData  = 8'h00;
    bus.InstrAddr = 16'h0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.CpuNReset !== 1'b0) begin failures++; $display("FAIL reset_cpu_nreset: got %b expected 0", bus.CpuNReset); end
    checks++;
    if (bus.Loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded: got %b expected 0", bus.Loaded); end
    checks++;
    if (bus.LoadReady !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %b expected 1", bus.LoadReady); end
    checks++;
    if (bus.LoadError !== 1'b0) begin failures++; $display("FAIL reset_load_error: got %b expected 0", bus.LoadError); end
    checks++;
    if (bus.InstrMem !== 32'h0) begin failures++; $display("FAIL reset_fetch0: got %h expected 00000000", bus.InstrMem); end
  endtask

  task automatic test_basic(input int mode, input string name);
    byte_q_t s;
    word_q_t w;
    bit      early, stuck;
    int          addrs [6] = '{32'h0000, 32'h0004, 32'h0008, 32'h0006, 32'h1000, 32'h0001};
    logic [31:0] exps  [6] = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h12345678};
    apply_reset();
    w = '{32'h12345678, 32'hDEADBEEF};
    s = make_stream(w);
    send_bytes(s, mode, early, stuck);
    checks++;
    if (stuck || early) begin failures++; $display("FAIL %s_release_timing: early=%b stuck=%b expected both 0", name, early, stuck); end
    checks++;
    if (bus.Loaded !== 1'b1 || bus.CpuNReset !== 1'b1) begin
      failures++; $display("FAIL %s_run: Loaded=%b CpuNReset=%b expected 1 1", name, bus.Loaded, bus.CpuNReset);
    end
    checks++;
    if (bus.LoadReady !== 1'b0) begin failures++; $display("FAIL %s_run_ready: got %b expected 0", name, bus.LoadReady); end
    for (int k = 0; k < 6; k++) begin
      bus.InstrAddr = 16'(addrs[k]);
      #1;
      checks++;
      if (bus.InstrMem !== exps[k]) begin
        failures++; $display("FAIL %s_fetch addr=%h: got %h expected %h", name, addrs[k], bus.InstrMem, exps[k]);
      end
    end
  endtask

  task automatic test_abort();
    byte_q_t part;
    byte_q_t s;
    word_q_t w;
    bit      early, stuck;
    apply_reset();
    part = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_bytes(part, 0, early, stuck);
    @(negedge Clock);
    Reset = 1'b1;
    bus.LoadValid = 1'b1;
    bus.LoadData  = 8'h7F;
    repeat (2) begin
      @(negedge Clock);
      checks++;
      if (bus.CpuNReset !== 1'b0) begin failures++; $display("FAIL abort_hold_cpu_reset: got %b expected 0", bus.CpuNReset); end
    end
    Reset = 1'b0;
    bus.LoadValid = 1'b0;
    exp_loaded = 1'b0; exp_n = 0; exp_words.delete();
    w = '{32'h11223344};
    s = make_stream(w);
    send_bytes(s, 0, early, stuck);
    exp_words = w; exp_n = 1; exp_loaded = 1'b1;
    checks++;
    if (stuck || bus.Loaded !== 1'b1) begin failures++; $display("FAIL abort_reload: Loaded=%b stuck=%b expected 1 0", bus.Loaded, stuck); end
    for (int a = 0; a < 12; a += 4) begin
      bus.InstrAddr = 16'(a);
      #1;
      checks++;
      if (bus.InstrMem !== exp_fetch(a)) begin
        failures++; $display("FAIL abort_fetch addr=%h: got %h expected %h", a, bus.InstrMem, exp_fetch(a));
      end
    end
  endtask

  task automatic test_zero();
    byte_q_t s;
    word_q_t w;
    bit      early, stuck;
    int      addrs [3] = '{32'h0000, 32'h0004, 32'h1000};
    apply_reset();
    w.delete();
    s = make_stream(w);
    send_bytes(s, 0, early, stuck);
    exp_loaded = 1'b1; exp_n = 0;
    checks++;
    if (stuck || bus.Loaded !== 1'b1 || bus.CpuNReset !== 1'b1) begin
      failures++; $display("FAIL zero_run: Loaded=%b CpuNReset=%b stuck=%b expected 1 1 0", bus.Loaded, bus.CpuNReset, stuck);
    end
    foreach (addrs[k]) begin
      bus.InstrAddr = 16'(addrs[k]);
      #1;
      checks++;
      if (bus.InstrMem !== 32'h0) begin
        failures++; $display("FAIL zero_fetch addr=%h: got %h expected 00000000", addrs[k], bus.InstrMem);
      end
    end
  endtask

  task automatic test_random();
    byte_q_t s;
    word_q_t w;
    bit      early, stuck;
    int      a;
    for (int iter = 0; iter < 5; iter++) begin
      apply_reset();
      w.delete();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) w.push_back($urandom);
      s = make_stream(w);
      send_bytes(s, 2, early, stuck);
      exp_words = w; exp_n = w.size(); exp_loaded = 1'b1;
      checks++;
      if (stuck || early || bus.Loaded !== 1'b1) begin
        failures++; $display("FAIL random_load%0d: Loaded=%b early=%b stuck=%b expected 1 0 0", iter, bus.Loaded, early, stuck);
      end
      for (int k = 0; k < 16; k++) begin
        a = (k < 12) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 65535));
        bus.InstrAddr = 16'(a);
        #1;
        checks++;
        if (bus.InstrMem !== exp_fetch(a)) begin
          failures++; $display("FAIL random_fetch%0d addr=%h: got %h expected %h", iter, a, bus.InstrMem, exp_fetch(a));
        end
      end
    end
  endtask

  task automatic test_overflow();
    byte_q_t s;
    word_q_t w;
    bit      early, stuck;
    int      addrs [6] = '{0, 4, 4 * (DEPTH - 2), 4 * (DEPTH - 1), 4 * DEPTH, 4 * DEPTH + 4};
    apply_reset();
    w.delete();
    for (int k = 0; k < DEPTH + 2; k++) w.push_back($urandom);
    s = make_stream(w);
    send_bytes(s, 0, early, stuck);
    exp_words = w; exp_n = w.size(); exp_loaded = 1'b1;
    checks++;
    if (stuck || early || bus.Loaded !== 1'b1) begin
      failures++; $display("FAIL overflow_load: Loaded=%b early=%b stuck=%b expected 1 0 0", bus.Loaded, early, stuck);
    end
    foreach (addrs[k]) begin
      bus.InstrAddr = 16'(addrs[k]);
      #1;
      checks++;
      if (bus.InstrMem !== exp_fetch(addrs[k])) begin
        failures++; $display("FAIL overflow_fetch addr=%h: got %h expected %h", addrs[k], bus.InstrMem, exp_fetch(addrs[k]));
      end
    end
  endtask

  task automatic test_run_ignores();
    bit ready_seen = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      bus.LoadValid = 1'b1;
      bus.LoadData  = 8'($urandom);
      if (bus.LoadReady !== 1'b0) ready_seen = 1'b1;
    end
    @(negedge Clock);
    bus.LoadValid = 1'b0;
    checks++;
    if (ready_seen) begin failures++; $display("FAIL run_ignores_ready: LoadReady rose in RUN, expected 0"); end
    checks++;
    if (bus.Loaded !== 1'b1 || bus.CpuNReset !== 1'b1) begin
      failures++; $display("FAIL run_ignores_state: Loaded=%b CpuNReset=%b expected 1 1", bus.Loaded, bus.CpuNReset);
    end
    for (int a = 0; a < 8; a += 4) begin
      bus.InstrAddr = 16'(a);
      #1;
      checks++;
      if (bus.InstrMem !== exp_fetch(a)) begin
        failures++; $display("FAIL run_ignores_fetch addr=%h: got %h expected %h", a, bus.InstrMem, exp_fetch(a));
      end
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t s;
    bit      early, stuck;
    apply_reset();
    s = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(s, 0, early, stuck);
    bus.InstrAddr = 16'h0000;
    #1;
    checks++;
    if (bus.Loaded !== 1'b1 || bus.InstrMem !== 32'h1) begin
      failures++; $display("FAIL checksum_good: Loaded=%b fetch=%h expected 1 00000001", bus.Loaded, bus.InstrMem);
    end
    apply_reset();
    s = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_bytes(s, 0, early, stuck);
    repeat (3) @(negedge Clock);
    checks++;
    if (bus.LoadError !== 1'b1 || bus.CpuNReset !== 1'b0 || bus.LoadReady !== 1'b0 || bus.Loaded !== 1'b0) begin
      failures++;
      $display("FAIL checksum_bad: LoadError=%b CpuNReset=%b LoadReady=%b Loaded=%b expected 1 0 0 0",
               bus.LoadError, bus.CpuNReset, bus.LoadReady, bus.Loaded);
    end
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "stall");
    test_abort();
    test_zero();
    test_random();
    test_overflow();
    test_run_ignores();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
